apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Synthesizable APB3 initiator (requester).
- Converts a simple valid/ready request channel and response channel into single APB transfers towards one completer, e.g. gpio_apb.
- Replaces the behavioural bench tester as the bus driver, so an on-chip controller or a host bridge can reach APB peripherals.
- Includes a PREADY timeout so a hung completer cannot stall the requester.

Parameters:
ADDR_WIDTH, 32, width of PADDR and req_addr
DATA_WIDTH, 32, width of PWDATA/PRDATA and request/response data
TIMEOUT, 255, max ACCESS-phase cycles with PREADY=0 before abort; 0 disables timeout

Ports:
PCLK  input  1  clock for all logic
PRESETn  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  bridge accepts request
req_write  input  1  1=write, 0=read
req_addr  input  ADDR_WIDTH  transfer address
req_wdata  input  DATA_WIDTH  write data
resp_valid  output  1  response present
resp_ready  input  1  requester takes response
resp_rdata  output  DATA_WIDTH  read data (0 for writes and timeouts)
resp_err  output  1  PSLVERR seen or timeout
resp_timeout  output  1  transfer aborted by timeout
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PADDR  output  ADDR_WIDTH  APB address
PWRITE  output  1  APB direction
PWDATA  output  DATA_WIDTH  APB write data
PRDATA  input  DATA_WIDTH  APB read data
PREADY  input  1  APB ready
PSLVERR  input  1  APB error

Behaviour:
- Clock, reset, and reset values:
  - One clock, PCLK. Reset PRESETn is asynchronous and active-low.
  - While PRESETn=0, all outputs are 0 and the FSM is in IDLE.
  - Reset asserted mid-transfer drops PSEL/PENABLE immediately and discards the pending response.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1 only in IDLE.
  - On req_valid&&req_ready: latch write/addr/wdata into PWRITE/PADDR/PWDATA; next state SETUP with PSEL=1, PENABLE=0.
- SETUP: exactly one cycle; next state ACCESS with PENABLE=1. PSEL, PADDR, PWRITE and PWDATA are unchanged.
- ACCESS:
  - Sample PREADY each cycle.
  - PREADY=1:
    - Capture PRDATA into resp_rdata if read, else resp_rdata=0.
    - resp_err=PSLVERR, resp_timeout=0.
    - Next cycle: PSEL=0, PENABLE=0, resp_valid=1, state RESP.
  - PREADY=0:
    - Wait counter increments; the counter is cleared on entering SETUP.
    - If TIMEOUT!=0 and the counter reaches TIMEOUT while PREADY=0: next cycle PSEL=0, PENABLE=0, resp_valid=1, resp_err=1, resp_timeout=1, resp_rdata=0, state RESP.
  - PREADY=1 in the same cycle the counter reaches TIMEOUT: treated as normal completion.
  - PSLVERR is ignored when PREADY=0.
- RESP:
  - resp_valid and the resp_* fields are held stable until resp_ready=1.
  - Then resp_valid=0 and state IDLE.
  - resp_ready while resp_valid=0 has no effect.
- PADDR, PWRITE and PWDATA hold their last values while idle; no toggling between transfers.
- Throughput, with resp_ready tied high and PREADY=1 immediately:
  - Accept at cycle N; SETUP at N+1; ACCESS at N+2; resp_valid at N+3; req_ready at N+4.
  - Minimum 4 cycles per transfer.
- Timeout timing: with TIMEOUT=T and PREADY stuck low, ACCESS lasts exactly T cycles.
- Only one transfer is outstanding at a time; no pipelining.
- Counter width: $clog2(TIMEOUT+1), minimum 1 bit.

Test Plan:
- Write, zero wait: req_write=1, addr=0x10, wdata=0xA5A5_0F0F, PREADY=1:
  - PSEL rises 1 cycle after accept, PENABLE 1 cycle later.
  - PADDR/PWDATA stable across both phases.
  - resp_valid one cycle after ACCESS, resp_err=0, resp_rdata=0.
- Read, 3 wait states: addr=0x14, completer drives PRDATA=0x0000_00C3 with PREADY=1 on the 4th ACCESS cycle:
  - PENABLE high exactly 4 cycles.
  - resp_rdata=0x0000_00C3, resp_err=0.
- Error: read with PSLVERR=1 and PREADY=1 → resp_err=1, resp_timeout=0.
- Error ignored while not ready: PSLVERR=1 with PREADY=0 in an earlier cycle, clean completion → resp_err=0.
- Timeout: TIMEOUT=8, PREADY held 0:
  - ACCESS lasts 8 cycles, PSEL drops.
  - resp_err=1, resp_timeout=1, resp_rdata=0.
  - Next request proceeds normally.
- Response backpressure and throughput:
  - resp_ready=0 for 5 cycles → resp_valid and resp fields stable, req_ready=0 throughout.
  - Back-to-back requests with resp_ready=1 → one transfer per 4 cycles.
- Reset mid-ACCESS: PRESETn=0 while PENABLE=1 → PSEL/PENABLE/resp_valid=0 asynchronously; after release req_ready=1 and no stale response.
- End to end: bridge connected to gpio_apb, write then read back a GPIO output register → data matches.

Source files
------------

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - APB3 requester bridging a valid/ready request/response channel
module apb_master_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  resp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);
    // Wait counter only has to reach TIMEOUT-1: the abort fires on the cycle it would reach TIMEOUT.
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int LAST_I = (TIMEOUT < 1) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = LAST_I[CNT_W-1:0];

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [CNT_W-1:0]        r_wait_cnt;

    logic                    r_req_ready, w_req_ready;
    logic                    r_resp_valid, w_resp_valid;
    logic [DATA_WIDTH-1:0]   r_resp_rdata, w_resp_rdata;
    logic                    r_resp_err, w_resp_err;
    logic                    r_resp_timeout, w_resp_timeout;
    logic                    r_psel, w_psel;
    logic                    r_penable, w_penable;
    logic [ADDR_WIDTH-1:0]   r_paddr, w_paddr;
    logic                    r_pwrite, w_pwrite;
    logic [DATA_WIDTH-1:0]   r_pwdata, w_pwdata;

    logic                    w_accept;
    logic                    w_timeout;

    // req_ready is only ever high in IDLE, so it doubles as the idle qualifier
    assign w_accept  = req_valid && r_req_ready;
    assign w_timeout = (TIMEOUT != 0) && !PREADY && (r_wait_cnt == LAST_WAIT);

    assign req_ready    = r_req_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_rdata   = r_resp_rdata;
    assign resp_err     = r_resp_err;
    assign resp_timeout = r_resp_timeout;
    assign PSEL         = r_psel;
    assign PENABLE      = r_penable;
    assign PADDR        = r_paddr;
    assign PWRITE       = r_pwrite;
    assign PWDATA       = r_pwdata;

    // State register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept) w_next_state = S_SETUP;
            S_SETUP:  w_next_state = S_ACCESS;
            S_ACCESS: if (PREADY || w_timeout) w_next_state = S_RESP;
            S_RESP:   if (resp_ready) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the upcoming state
    always_comb begin
        w_psel         = (w_next_state == S_SETUP) || (w_next_state == S_ACCESS);
        w_penable      = (w_next_state == S_ACCESS);
        w_req_ready    = (w_next_state == S_IDLE);
        w_resp_valid   = (w_next_state == S_RESP);
        w_paddr        = r_paddr;
        w_pwrite       = r_pwrite;
        w_pwdata       = r_pwdata;
        w_resp_rdata   = r_resp_rdata;
        w_resp_err     = r_resp_err;
        w_resp_timeout = r_resp_timeout;
        if (w_accept) begin
            w_paddr  = req_addr;
            w_pwrite = req_write;
            w_pwdata = req_wdata;
        end
        if (r_state == S_ACCESS) begin
            if (PREADY) begin
                w_resp_rdata   = r_pwrite ? '0 : PRDATA;
                w_resp_err     = PSLVERR;
                w_resp_timeout = 1'b0;
            end else if (w_timeout) begin
                w_resp_rdata   = '0;
                w_resp_err     = 1'b1;
                w_resp_timeout = 1'b1;
            end
        end
    end

    // Output registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_req_ready    <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_resp_rdata   <= '0;
            r_resp_err     <= 1'b0;
            r_resp_timeout <= 1'b0;
            r_psel         <= 1'b0;
            r_penable      <= 1'b0;
            r_paddr        <= '0;
            r_pwrite       <= 1'b0;
            r_pwdata       <= '0;
        end else begin
            r_req_ready    <= w_req_ready;
            r_resp_valid   <= w_resp_valid;
            r_resp_rdata   <= w_resp_rdata;
            r_resp_err     <= w_resp_err;
            r_resp_timeout <= w_resp_timeout;
            r_psel         <= w_psel;
            r_penable      <= w_penable;
            r_paddr        <= w_paddr;
            r_pwrite       <= w_pwrite;
            r_pwdata       <= w_pwdata;
        end
    end

    // ACCESS wait counter, restarted for every new transfer
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wait_cnt <= '0;
        end else if (w_accept) begin
            r_wait_cnt <= '0;
        end else if ((r_state == S_ACCESS) && !PREADY) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - bench for apb_master_bridge with per-cycle reference model
module tb_apb_master_bridge;
    localparam int TMO = 8;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        resp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_timeout(resp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    // Completer: PREADY after c_waits not-ready ACCESS cycles, or never when hung
    int          c_waits = 0;
    logic        c_hang = 1'b0;
    logic        c_err = 1'b0;
    logic        c_err_early = 1'b0;
    logic        c_mem = 1'b0;
    logic [31:0] c_rdata = '0;
    logic [31:0] mem [16];
    int          acc_n = 0;

    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            acc_n = acc_n + 1;
            PREADY  = !c_hang && (acc_n > c_waits);
            PSLVERR = PREADY ? c_err : c_err_early;
            PRDATA  = c_mem ? mem[PADDR[5:2]] : c_rdata;
            if (c_mem && PREADY && PWRITE) mem[PADDR[5:2]] = PWDATA;
        end else begin
            acc_n   = 0;
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
        end
    end

    // Reference model: transfer-level view of what each output must be after every edge
    logic        e_psel, e_pen, e_rv, e_rr, e_pwrite, e_err, e_to;
    logic [31:0] e_paddr, e_pwdata, e_rdata;
    int          e_n;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            e_psel <= 0; e_pen <= 0; e_rv <= 0; e_rr <= 0; e_pwrite <= 0;
            e_err <= 0; e_to <= 0; e_paddr <= 0; e_pwdata <= 0; e_rdata <= 0; e_n <= 0;
        end else if (e_rv) begin
            if (resp_ready) begin
                e_rv <= 0;
                e_rr <= 1;
            end
        end else if (e_psel && !e_pen) begin
            e_pen <= 1;
            e_n   <= 0;
        end else if (e_pen) begin
            e_n <= e_n + 1;
            if (PREADY) begin
                e_psel <= 0; e_pen <= 0; e_rv <= 1;
                e_rdata <= e_pwrite ? 32'h0 : PRDATA;
                e_err <= PSLVERR; e_to <= 0;
            end else if (TMO != 0 && e_n + 1 == TMO) begin
                e_psel <= 0; e_pen <= 0; e_rv <= 1;
                e_rdata <= 32'h0; e_err <= 1; e_to <= 1;
            end
        end else if (e_rr) begin
            if (req_valid) begin
                e_rr <= 0; e_psel <= 1;
                e_paddr <= req_addr; e_pwrite <= req_write; e_pwdata <= req_wdata;
            end
        end else begin
            e_rr <= 1;
        end
    end

    task automatic cmpv(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        cmpv(name, act, exp);
    endtask

    // One vector per cycle: every output against the model
    task automatic cmp_cycle();
        n_vec++;
        cmpv("PSEL", PSEL, e_psel);
        cmpv("PENABLE", PENABLE, e_pen);
        cmpv("resp_valid", resp_valid, e_rv);
        cmpv("req_ready", req_ready, e_rr);
        cmpv("PADDR", PADDR, e_paddr);
        cmpv("PWRITE", PWRITE, e_pwrite);
        cmpv("PWDATA", PWDATA, e_pwdata);
        if (e_rv) begin
            cmpv("resp_rdata", resp_rdata, e_rdata);
            cmpv("resp_err", resp_err, e_err);
            cmpv("resp_timeout", resp_timeout, e_to);
        end
    endtask

    task automatic tick();
        @(negedge PCLK);
        cmp_cycle();
    endtask

    // Issue one request and wait for its response; returns at the negedge resp_valid is seen
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output logic to,
                        output int lat, output int pen);
        int g;
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        g = 0;
        while (!req_ready && g < 100) begin
            tick();
            g++;
        end
        if (g >= 100) chk("accept_bound", 0, 1);
        tick();
        req_valid = 1'b0;
        lat = 1;
        pen = 0;
        while (!resp_valid && lat < 100) begin
            if (PENABLE) pen++;
            tick();
            lat++;
        end
        if (lat >= 100) chk("resp_bound", 0, 1);
        rd = resp_rdata;
        er = resp_err;
        to = resp_timeout;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er, to;
        int          lat, pen, na;
        int          acc_t [3];

        tick();
        tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_psel", PSEL, 0);
        chk("rst_paddr", PADDR, 0);
        PRESETn = 1'b1;
        tick();
        chk("post_rst_req_ready", req_ready, 1);

        // write, zero wait
        xfer(1'b1, 32'h10, 32'hA5A5_0F0F, rd, er, to, lat, pen);
        chk("wr_latency", lat, 3);
        chk("wr_penable_cycles", pen, 1);
        chk("wr_err", er, 0);
        chk("wr_rdata", rd, 0);
        chk("wr_paddr", PADDR, 32'h10);
        tick();

        // read, 3 wait states
        c_waits = 3; c_rdata = 32'h0000_00C3;
        xfer(1'b0, 32'h14, 32'h0, rd, er, to, lat, pen);
        chk("rd_penable_cycles", pen, 4);
        chk("rd_rdata", rd, 32'hC3);
        chk("rd_err", er, 0);
        tick();

        // PSLVERR with PREADY
        c_waits = 0; c_err = 1'b1; c_rdata = 32'h1234_5678;
        xfer(1'b0, 32'h18, 32'h0, rd, er, to, lat, pen);
        chk("slverr_err", er, 1);
        chk("slverr_timeout", to, 0);
        tick();

        // PSLVERR only while not ready is ignored
        c_err = 1'b0; c_err_early = 1'b1; c_waits = 2;
        xfer(1'b0, 32'h1C, 32'h0, rd, er, to, lat, pen);
        chk("early_err_ignored", er, 0);
        tick();
        c_err_early = 1'b0;

        // timeout
        c_hang = 1'b1;
        xfer(1'b0, 32'h20, 32'h0, rd, er, to, lat, pen);
        chk("tmo_access_cycles", pen, TMO);
        chk("tmo_err", er, 1);
        chk("tmo_flag", to, 1);
        chk("tmo_rdata", rd, 0);
        chk("tmo_psel_dropped", PSEL, 0);
        tick();
        c_hang = 1'b0;
        c_waits = 1; c_rdata = 32'h0BAD_F00D;
        xfer(1'b0, 32'h24, 32'h0, rd, er, to, lat, pen);
        chk("after_tmo_rdata", rd, 32'h0BAD_F00D);
        chk("after_tmo_timeout", to, 0);
        tick();

        // response backpressure
        c_waits = 0; c_rdata = 32'h0000_005A;
        resp_ready = 1'b0;
        xfer(1'b0, 32'h28, 32'h0, rd, er, to, lat, pen);
        repeat (5) tick();
        chk("bp_resp_valid", resp_valid, 1);
        chk("bp_req_ready", req_ready, 0);
        chk("bp_rdata", resp_rdata, 32'h5A);
        resp_ready = 1'b1;
        tick();
        chk("bp_released", resp_valid, 0);

        // back-to-back throughput
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h0000_1111;
        na = 0;
        for (int i = 0; i < 11; i++) begin
            if (req_ready && na < 3) begin
                acc_t[na] = i;
                na++;
            end
            tick();
            req_wdata = req_wdata + 32'h1;
        end
        req_valid = 1'b0;
        chk("b2b_accepts", na, 3);
        if (na == 3) begin
            chk("b2b_spacing0", acc_t[1] - acc_t[0], 4);
            chk("b2b_spacing1", acc_t[2] - acc_t[1], 4);
        end
        repeat (6) tick();

        // reset during ACCESS
        c_hang = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h34;
        na = 0;
        while (!req_ready && na < 100) begin
            tick();
            na++;
        end
        tick();
        req_valid = 1'b0;
        tick();
        chk("rst_mid_penable_before", PENABLE, 1);
        #2 PRESETn = 1'b0;
        #1;
        chk("rst_mid_psel", PSEL, 0);
        chk("rst_mid_penable", PENABLE, 0);
        chk("rst_mid_resp_valid", resp_valid, 0);
        tick();
        PRESETn = 1'b1;
        c_hang = 1'b0;
        tick();
        chk("rst_mid_req_ready", req_ready, 1);
        tick();
        chk("rst_mid_no_stale", resp_valid, 0);

        // end to end through a register-file completer
        c_mem = 1'b1;
        xfer(1'b1, 32'h20, 32'hDEAD_BEEF, rd, er, to, lat, pen);
        tick();
        xfer(1'b0, 32'h20, 32'h0, rd, er, to, lat, pen);
        chk("e2e_readback", rd, 32'hDEAD_BEEF);
        chk("e2e_err", er, 0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
